// File: rtl/spi_txn_ctrl_pkg.sv
// spi_txn_ctrl_pkg: shared state encoding and defaults for the SPI
// transaction sequencer (length width, read-phase fill byte).
package spi_txn_ctrl_pkg;

    localparam int         LEN_W_DEF   = 8;
    localparam logic [7:0] RD_FILL_DEF = 8'h00;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_WR_WAIT,
        ST_WR_XFER,
        ST_RD_WAIT,
        ST_RD_XFER,
        ST_HOLD,
        ST_GAP
    } state_t;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/spi_txn_ctrl.sv
// spi_txn_ctrl: one request = write N bytes then read M bytes under a single
// chip-select, with CS setup/hold/gap timing, driving a Mode-0 byte engine.
//  Ports: clk/rst (sync, active high); req_* request handshake with lengths;
//  wr_* write-byte stream in; rd_* read-byte stream out (rd_last on final);
//  txn_done/busy status; spi_cs_n; start_xfer/tx_byte to the byte engine;
//  xfer_active/xfer_done/rx_byte from the byte engine.
module spi_txn_ctrl
    import spi_txn_ctrl_pkg::*;
#(
    parameter int         LEN_W        = LEN_W_DEF,
    parameter int         CS_SETUP_CYC = 4,
    parameter int         CS_HOLD_CYC  = 4,
    parameter int         CS_GAP_CYC   = 8,
    parameter logic [7:0] RD_FILL      = RD_FILL_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [LEN_W-1:0] req_wr_len,
    input  logic [LEN_W-1:0] req_rd_len,
    input  logic             wr_valid,
    output logic             wr_ready,
    input  logic [7:0]       wr_data,
    output logic             rd_valid,
    input  logic             rd_ready,
    output logic [7:0]       rd_data,
    output logic             rd_last,
    output logic             txn_done,
    output logic             busy,
    output logic             spi_cs_n,
    output logic             start_xfer,
    output logic [7:0]       tx_byte,
    input  logic             xfer_active,
    input  logic             xfer_done,
    input  logic [7:0]       rx_byte
);

    localparam int CS_MAX = max3(CS_SETUP_CYC, CS_HOLD_CYC, CS_GAP_CYC);
    localparam int CS_W   = (CS_MAX > 1) ? $clog2(CS_MAX) : 1;

    localparam logic [CS_W-1:0] SETUP_LD = CS_W'(CS_SETUP_CYC - 1);
    localparam logic [CS_W-1:0] HOLD_LD  = CS_W'(CS_HOLD_CYC - 1);
    localparam logic [CS_W-1:0] GAP_LD   = CS_W'(CS_GAP_CYC - 1);

    localparam logic [LEN_W-1:0] ONE = LEN_W'(1);

    state_t            state;
    state_t            state_d;
    logic [LEN_W-1:0]  wr_cnt;
    logic [LEN_W-1:0]  rd_cnt;
    logic [CS_W-1:0]   cs_cnt;
    logic              cs_n_q;
    logic              live;

    logic              accept;
    logic              zero_req;
    logic              issue_wr;
    logic              issue_rd;
    logic              can_start;
    logic              cs_zero;
    logic              rd_take;

    // A start registered last cycle may not yet show as xfer_active.
    assign can_start = !xfer_active && !start_xfer;
    assign cs_zero   = (cs_cnt == '0);
    assign rd_take   = rd_valid && rd_ready;
    assign req_ready = (state == ST_IDLE) && live;
    assign accept    = req_valid && req_ready;
    assign spi_cs_n  = cs_n_q | rst;

    always_comb begin
        state_d  = state;
        zero_req = 1'b0;
        issue_wr = 1'b0;
        issue_rd = 1'b0;
        wr_ready = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (accept) begin
                    if (req_wr_len == '0 && req_rd_len == '0)
                        zero_req = 1'b1;
                    else
                        state_d = ST_SETUP;
                end
            end
            ST_SETUP: begin
                if (cs_zero)
                    state_d = (wr_cnt != '0) ? ST_WR_WAIT : ST_RD_WAIT;
            end
            ST_WR_WAIT: begin
                wr_ready = can_start;
                if (wr_valid && can_start) begin
                    issue_wr = 1'b1;
                    state_d  = ST_WR_XFER;
                end
            end
            ST_WR_XFER: begin
                if (xfer_done) begin
                    if (wr_cnt > ONE)
                        state_d = ST_WR_WAIT;
                    else if (rd_cnt != '0)
                        state_d = ST_RD_WAIT;
                    else
                        state_d = ST_HOLD;
                end
            end
            ST_RD_WAIT: begin
                if (can_start && (!rd_valid || rd_ready)) begin
                    issue_rd = 1'b1;
                    state_d  = ST_RD_XFER;
                end
            end
            ST_RD_XFER: begin
                if (xfer_done)
                    state_d = (rd_cnt > ONE) ? ST_RD_WAIT : ST_HOLD;
            end
            ST_HOLD: begin
                if (cs_zero)
                    state_d = ST_GAP;
            end
            ST_GAP: begin
                if (cs_zero)
                    state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            live       <= 1'b0;
            wr_cnt     <= '0;
            rd_cnt     <= '0;
            cs_cnt     <= '0;
            cs_n_q     <= 1'b1;
            busy       <= 1'b0;
            txn_done   <= 1'b0;
            start_xfer <= 1'b0;
            tx_byte    <= 8'h00;
            rd_valid   <= 1'b0;
            rd_data    <= 8'h00;
            rd_last    <= 1'b0;
        end else begin
            live       <= 1'b1;
            state      <= state_d;
            start_xfer <= issue_wr | issue_rd;
            txn_done   <= zero_req |
                          (state == ST_GAP && state_d == ST_IDLE);

            // One timer serves SETUP, HOLD and GAP; reload on entry.
            if (state_d != state) begin
                unique case (state_d)
                    ST_SETUP: cs_cnt <= SETUP_LD;
                    ST_HOLD:  cs_cnt <= HOLD_LD;
                    ST_GAP:   cs_cnt <= GAP_LD;
                    default:  cs_cnt <= '0;
                endcase
            end else if (!cs_zero) begin
                cs_cnt <= cs_cnt - CS_W'(1);
            end

            if (accept) begin
                wr_cnt <= req_wr_len;
                rd_cnt <= req_rd_len;
            end

            if (state == ST_IDLE && state_d == ST_SETUP) begin
                cs_n_q <= 1'b0;
                busy   <= 1'b1;
            end
            if (state == ST_HOLD && state_d == ST_GAP)
                cs_n_q <= 1'b1;
            if (state == ST_GAP && state_d == ST_IDLE)
                busy <= 1'b0;

            if (issue_wr)
                tx_byte <= wr_data;
            else if (issue_rd)
                tx_byte <= RD_FILL;

            if (state == ST_WR_XFER && xfer_done && wr_cnt != '0)
                wr_cnt <= wr_cnt - ONE;

            // New read data wins; issue is gated so it never
            // overwrites an unconsumed byte.
            if (state == ST_RD_XFER && xfer_done) begin
                rd_data  <= rx_byte;
                rd_valid <= 1'b1;
                rd_last  <= (rd_cnt == ONE);
                if (rd_cnt != '0)
                    rd_cnt <= rd_cnt - ONE;
            end else if (rd_take) begin
                rd_valid <= 1'b0;
                rd_last  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_spi_txn_ctrl.sv
// tb_spi_txn_ctrl: directed scenarios for spi_txn_ctrl against a
// behavioural byte engine that returns queued slave bytes.
module tb_spi_txn_ctrl;

    localparam int ENG_CYC = 16;
    localparam int SETUP_C = 4;
    localparam int HOLD_C  = 4;
    localparam int GAP_C   = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic       req_valid;
    logic       req_ready;
    logic [7:0] req_wr_len;
    logic [7:0] req_rd_len;
    logic       wr_valid = 1'b0;
    logic       wr_ready;
    logic [7:0] wr_data = 8'h00;
    logic       rd_valid;
    logic       rd_ready;
    logic [7:0] rd_data;
    logic       rd_last;
    logic       txn_done;
    logic       busy;
    logic       spi_cs_n;
    logic       start_xfer;
    logic [7:0] tx_byte;
    logic       xfer_active;
    logic       xfer_done;
    logic [7:0] rx_byte;

    int tests = 0;
    int fails = 0;

    logic [7:0] mosi_q[$];
    logic [7:0] miso_q[$];
    logic [7:0] wr_q[$];
    logic [8:0] rx_q[$];
    int         wr_delay = 0;
    int         wr_gap   = 0;
    int         eng_cnt;

    int cyc = 0, n_start = 0, n_done = 0, n_acc = 0, n_fall = 0;
    int n_rise = 0, viol = 0;
    int t_fall = 0, t_rise = 0, t_done = 0;
    int min_setup = 1000, min_hold = 1000, min_gap = 1000;
    bit setup_pend = 0, gap_pend = 0;
    logic cs_prev = 1'b1;

    spi_txn_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_wr_len  (req_wr_len),
        .req_rd_len  (req_rd_len),
        .wr_valid    (wr_valid),
        .wr_ready    (wr_ready),
        .wr_data     (wr_data),
        .rd_valid    (rd_valid),
        .rd_ready    (rd_ready),
        .rd_data     (rd_data),
        .rd_last     (rd_last),
        .txn_done    (txn_done),
        .busy        (busy),
        .spi_cs_n    (spi_cs_n),
        .start_xfer  (start_xfer),
        .tx_byte     (tx_byte),
        .xfer_active (xfer_active),
        .xfer_done   (xfer_done),
        .rx_byte     (rx_byte)
    );

    always #5 clk = ~clk;

    // Behavioural byte engine.
    always @(posedge clk) begin
        if (rst) begin
            xfer_active <= 1'b0;
            xfer_done   <= 1'b0;
            rx_byte     <= 8'h00;
            eng_cnt     <= 0;
        end else begin
            xfer_done <= 1'b0;
            if (start_xfer && !xfer_active) begin
                xfer_active <= 1'b1;
                eng_cnt     <= ENG_CYC - 1;
                mosi_q.push_back(tx_byte);
            end else if (xfer_active) begin
                if (eng_cnt == 0) begin
                    xfer_active <= 1'b0;
                    xfer_done   <= 1'b1;
                    if (miso_q.size() > 0)
                        rx_byte <= miso_q.pop_front();
                    else
                        rx_byte <= 8'hFF;
                end else begin
                    eng_cnt <= eng_cnt - 1;
                end
            end
        end
    end

    // Write-byte source.
    always @(negedge clk) begin
        if (wr_delay > 0) begin
            wr_delay--;
            wr_valid = 1'b0;
        end else if (wr_q.size() > 0) begin
            wr_valid = 1'b1;
            wr_data  = wr_q[0];
        end else begin
            wr_valid = 1'b0;
        end
    end

    // Monitor: handshakes, protocol and CS timing.
    always @(posedge clk) begin
        cyc++;
        if (!rst) begin
            if (start_xfer && xfer_active) viol++;
            if (!spi_cs_n && cs_prev) begin
                n_fall++;
                t_fall     = cyc;
                setup_pend = 1;
            end
            if (start_xfer) begin
                n_start++;
                if (setup_pend) begin
                    if (cyc - t_fall < min_setup)
                        min_setup = cyc - t_fall;
                    setup_pend = 0;
                end
            end
            if (spi_cs_n && !cs_prev) begin
                n_rise++;
                t_rise = cyc;
                if (cyc - t_done < min_hold)
                    min_hold = cyc - t_done;
                gap_pend = 1;
            end
            if (xfer_done) t_done = cyc;
            if (req_valid && req_ready) begin
                n_acc++;
                if (gap_pend) begin
                    if (cyc - t_rise < min_gap)
                        min_gap = cyc - t_rise;
                    gap_pend = 0;
                end
            end
            if (txn_done) n_done++;
            if (rd_valid && rd_ready)
                rx_q.push_back({rd_last, rd_data});
            if (wr_valid && wr_ready) begin
                void'(wr_q.pop_front());
                wr_delay = wr_gap;
            end
        end
        cs_prev = spi_cs_n;
    end

    task automatic send_req(input logic [7:0] wl,
                            input logic [7:0] rl,
                            output bit ok);
        ok = 0;
        @(negedge clk);
        req_valid  = 1'b1;
        req_wr_len = wl;
        req_rd_len = rl;
        for (int i = 0; i < 300; i++) begin
            if (req_ready) begin
                ok = 1;
                break;
            end
            @(negedge clk);
        end
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic wait_done(input int target, output bit ok);
        ok = 0;
        for (int i = 0; i < 3000; i++) begin
            if (n_done >= target) begin
                ok = 1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        tests++;
        if ({req_ready, spi_cs_n, busy, rd_valid, start_xfer,
             wr_ready, txn_done, rd_last} !== 8'b0100_0000) begin
            fails++;
            $display("FAIL reset_ctl: got rdy=%b cs=%b busy=%b rv=%b st=%b wr=%b dn=%b rl=%b want 0,1,0,0,0,0,0,0",
                     req_ready, spi_cs_n, busy, rd_valid, start_xfer,
                     wr_ready, txn_done, rd_last);
        end
        tests++;
        if ({tx_byte, rd_data} !== 16'h0000) begin
            fails++;
            $display("FAIL reset_data: got tx=%h rd=%h want 00 00",
                     tx_byte, rd_data);
        end
        rst = 1'b0;
        @(negedge clk);
        tests++;
        if (req_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset_ready: got %b want 1", req_ready);
        end
    endtask

    task automatic test_wr1_rd3();
        bit ok;
        logic [7:0] exp_m [4] = '{8'h9F, 8'h00, 8'h00, 8'h00};
        logic [8:0] exp_r [3] = '{9'h0EF, 9'h040, 9'h118};
        int d0 = n_done;
        mosi_q.delete(); rx_q.delete();
        miso_q = '{8'hAA, 8'hEF, 8'h40, 8'h18};
        wr_q = '{8'h9F};
        rd_ready = 1'b1;
        send_req(8'd1, 8'd3, ok);
        wait_done(d0 + 1, ok);
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL t1_timeout: txn_done count %0d want %0d",
                     n_done - d0, 1);
        end
        repeat (3) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            tests++;
            if (mosi_q[i] !== exp_m[i]) begin
                fails++;
                $display("FAIL t1_mosi[%0d]: got %h want %h",
                         i, mosi_q[i], exp_m[i]);
            end
        end
        for (int i = 0; i < 3; i++) begin
            tests++;
            if (rx_q[i] !== exp_r[i]) begin
                fails++;
                $display("FAIL t1_rd[%0d]: got last=%b %h want last=%b %h",
                         i, rx_q[i][8], rx_q[i][7:0],
                         exp_r[i][8], exp_r[i][7:0]);
            end
        end
        tests++;
        if ((n_done - d0) !== 1 || mosi_q.size() !== 4 ||
            rx_q.size() !== 3) begin
            fails++;
            $display("FAIL t1_counts: done=%0d mosi=%0d rd=%0d want 1 4 3",
                     n_done - d0, mosi_q.size(), rx_q.size());
        end
    endtask

    task automatic test_rd_stall();
        bit ok;
        bit seen;
        int s0;
        logic [8:0] exp_r [3] = '{9'h0EF, 9'h040, 9'h118};
        int d0 = n_done;
        mosi_q.delete(); rx_q.delete();
        miso_q = '{8'hAA, 8'hEF, 8'h40, 8'h18};
        wr_q = '{8'h9F};
        rd_ready = 1'b0;
        send_req(8'd1, 8'd3, ok);
        seen = 0;
        for (int i = 0; i < 500; i++) begin
            if (rd_valid) begin
                seen = 1;
                break;
            end
            @(negedge clk);
        end
        tests++;
        if (!seen) begin
            fails++;
            $display("FAIL t2_first_byte: rd_valid %b want 1", rd_valid);
        end
        s0 = n_start;
        repeat (40) @(negedge clk);
        tests++;
        if (n_start !== s0 || spi_cs_n !== 1'b0 ||
            rd_valid !== 1'b1 || rd_data !== 8'hEF) begin
            fails++;
            $display("FAIL t2_stall: starts+%0d cs=%b rv=%b rd=%h want 0 0 1 ef",
                     n_start - s0, spi_cs_n, rd_valid, rd_data);
        end
        rd_ready = 1'b1;
        wait_done(d0 + 1, ok);
        repeat (3) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            tests++;
            if (rx_q[i] !== exp_r[i]) begin
                fails++;
                $display("FAIL t2_rd[%0d]: got %h want %h",
                         i, rx_q[i], exp_r[i]);
            end
        end
        tests++;
        if (!ok || viol !== 0) begin
            fails++;
            $display("FAIL t2_done: done_ok=%b start_while_active=%0d want 1 0",
                     ok, viol);
        end
    endtask

    task automatic test_wr_slow();
        bit ok;
        int s0;
        int r0 = n_rise;
        int d0 = n_done;
        mosi_q.delete(); rx_q.delete();
        wr_gap   = 30;
        wr_delay = 30;
        wr_q = '{8'h02, 8'hA5};
        send_req(8'd2, 8'd0, ok);
        s0 = n_start;
        repeat (20) @(negedge clk);
        tests++;
        if (spi_cs_n !== 1'b0 || xfer_active !== 1'b0 ||
            n_start !== s0) begin
            fails++;
            $display("FAIL t3_idle_wait: cs=%b act=%b starts+%0d want 0 0 0",
                     spi_cs_n, xfer_active, n_start - s0);
        end
        wait_done(d0 + 1, ok);
        wr_gap = 0;
        tests++;
        if (!ok || mosi_q.size() !== 2 || mosi_q[0] !== 8'h02 ||
            mosi_q[1] !== 8'hA5) begin
            fails++;
            $display("FAIL t3_order: ok=%b n=%0d b0=%h b1=%h want 1 2 02 a5",
                     ok, mosi_q.size(), mosi_q[0], mosi_q[1]);
        end
        tests++;
        if (n_rise - r0 !== 1) begin
            fails++;
            $display("FAIL t3_cs_rises: got %0d want 1", n_rise - r0);
        end
    endtask

    task automatic test_zero_len();
        bit ok;
        int f0 = n_fall;
        int s0 = n_start;
        int d0 = n_done;
        @(negedge clk);
        req_valid  = 1'b1;
        req_wr_len = 8'd0;
        req_rd_len = 8'd0;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        ok = (txn_done === 1'b1);
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL t4_done_pulse: got %b want 1", txn_done);
        end
        repeat (4) @(negedge clk);
        tests++;
        if (n_fall !== f0 || n_start !== s0 || n_done - d0 !== 1 ||
            busy !== 1'b0) begin
            fails++;
            $display("FAIL t4_quiet: falls+%0d starts+%0d done+%0d busy=%b want 0 0 1 0",
                     n_fall - f0, n_start - s0, n_done - d0, busy);
        end
    endtask

    task automatic test_mid_reset();
        bit ok;
        bit hit;
        int s0 = n_start;
        int d0;
        mosi_q.delete(); rx_q.delete();
        miso_q = '{8'h11, 8'h22, 8'h33, 8'h44};
        rd_ready = 1'b1;
        send_req(8'd0, 8'd4, ok);
        hit = 0;
        for (int i = 0; i < 500; i++) begin
            if (n_start - s0 >= 2 && xfer_active) begin
                hit = 1;
                break;
            end
            @(negedge clk);
        end
        rst = 1'b1;
        #1;
        tests++;
        if (!hit || spi_cs_n !== 1'b1) begin
            fails++;
            $display("FAIL t5_cs_immediate: reached=%b cs=%b want 1 1",
                     hit, spi_cs_n);
        end
        @(posedge clk);
        #1;
        tests++;
        if ({spi_cs_n, rd_valid, busy, start_xfer, req_ready} !==
            5'b10000) begin
            fails++;
            $display("FAIL t5_reset_state: cs=%b rv=%b busy=%b st=%b rdy=%b want 1 0 0 0 0",
                     spi_cs_n, rd_valid, busy, start_xfer, req_ready);
        end
        @(negedge clk);
        rst = 1'b0;
        miso_q.delete(); mosi_q.delete(); rx_q.delete();
        @(negedge clk);
        d0 = n_done;
        miso_q = '{8'hAA, 8'h5C};
        wr_q = '{8'h33};
        send_req(8'd1, 8'd1, ok);
        wait_done(d0 + 1, ok);
        repeat (2) @(negedge clk);
        tests++;
        if (!ok || rx_q.size() !== 1 || rx_q[0] !== 9'h15C ||
            mosi_q[0] !== 8'h33 || mosi_q[1] !== 8'h00) begin
            fails++;
            $display("FAIL t5_recover: ok=%b n=%0d rd=%h m0=%h m1=%h want 1 1 15c 33 00",
                     ok, rx_q.size(), rx_q[0], mosi_q[0], mosi_q[1]);
        end
    endtask

    task automatic test_back_to_back();
        bit ok;
        int a0 = n_acc;
        int d0 = n_done;
        rx_q.delete();
        min_setup = 1000; min_hold = 1000; min_gap = 1000;
        gap_pend = 0;
        miso_q = '{8'hAA, 8'hB1, 8'hAA, 8'hB2};
        wr_q = '{8'h11, 8'h22};
        rd_ready = 1'b1;
        @(negedge clk);
        req_valid  = 1'b1;
        req_wr_len = 8'd1;
        req_rd_len = 8'd1;
        ok = 0;
        for (int i = 0; i < 3000; i++) begin
            if (n_acc - a0 >= 2) req_valid = 1'b0;
            if (n_done - d0 >= 2) begin
                ok = 1;
                break;
            end
            @(negedge clk);
        end
        req_valid = 1'b0;
        repeat (2) @(negedge clk);
        tests++;
        if (!ok || rx_q.size() !== 2 || rx_q[0] !== 9'h1B1 ||
            rx_q[1] !== 9'h1B2) begin
            fails++;
            $display("FAIL t6_data: ok=%b n=%0d r0=%h r1=%h want 1 2 1b1 1b2",
                     ok, rx_q.size(), rx_q[0], rx_q[1]);
        end
        tests++;
        if (min_gap < GAP_C || min_gap == 1000) begin
            fails++;
            $display("FAIL t6_gap: got %0d want >= %0d", min_gap, GAP_C);
        end
        tests++;
        if (min_setup < SETUP_C || min_hold < HOLD_C) begin
            fails++;
            $display("FAIL t6_setup_hold: setup=%0d hold=%0d want >= %0d %0d",
                     min_setup, min_hold, SETUP_C, HOLD_C);
        end
        tests++;
        if (viol !== 0 || n_acc - a0 !== 2) begin
            fails++;
            $display("FAIL t6_protocol: start_while_active=%0d accepts=%0d want 0 2",
                     viol, n_acc - a0);
        end
    endtask

    initial begin
        rst        = 1'b1;
        req_valid  = 1'b0;
        req_wr_len = 8'd0;
        req_rd_len = 8'd0;
        rd_ready   = 1'b0;
        test_reset();
        test_wr1_rd3();
        test_rd_stall();
        test_wr_slow();
        test_zero_len();
        test_mid_reset();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
